// File: rtl/lap_mem_ctrl.sv
// lap_mem_ctrl: sequences lap capture, playback reads and clear sweep on the lap-result memory
module lap_mem_ctrl #(
  parameter int DEPTH        = 10,
  parameter int AW           = 4,
  parameter int DW           = 24,
  parameter int SCROLL_TICKS = 50_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lap_req,
  input  logic [DW-1:0] time_in,
  input  logic          view_req,
  input  logic          next_req,
  input  logic          auto_en,
  input  logic          clear_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wrdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rddata,
  output logic          view,
  output logic [AW-1:0] view_addr,
  output logic [DW-1:0] disp_data,
  output logic [AW:0]   lap_count,
  output logic          full,
  output logic          overflow,
  output logic          busy
);
  localparam int TW = $clog2(SCROLL_TICKS);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, VIEW, CLEAR} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic rd_pend, rd_iss, rd_val;
  logic lap_ok, lap_ovf, tick, step, enter, rd_want, clr_done;
  logic [AW:0] cnt_eff;
  logic [AW-1:0] va_n;
  assign view = state == VIEW;
  assign busy = state == CLEAR;
  // request decode, playback address stepping and next state
  always_comb begin
    lap_ok   = lap_req && state != CLEAR && !clear_req && !full;
    lap_ovf  = lap_req && state != CLEAR && !clear_req && full;
    cnt_eff  = lap_count + CW'(lap_ok);
    tick     = auto_en && timer == TW'(SCROLL_TICKS - 1);
    step     = state == VIEW && !view_req && !clear_req && (next_req || tick);
    enter    = state == IDLE && view_req && !clear_req && cnt_eff != '0;
    clr_done = state == CLEAR && mem_addr == AW'(DEPTH - 1);
    va_n     = enter ? '0 :
               step  ? (({1'b0, view_addr} + 1'b1 >= cnt_eff) ? '0 : view_addr + 1'b1) :
               view_addr;
    rd_want  = enter || step || rd_pend;
    state_n  = state == CLEAR ? (clr_done ? IDLE : CLEAR) :
               clear_req ? CLEAR :
               enter ? VIEW :
               (state == VIEW && view_req) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // memory port sequencing, lap bookkeeping, scroll timer and playback latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer      <= '0;
      rd_pend    <= 1'b0;
      rd_iss     <= 1'b0;
      rd_val     <= 1'b0;
      mem_addr   <= '0;
      mem_wrdata <= '0;
      mem_we     <= 1'b0;
      view_addr  <= '0;
      disp_data  <= '0;
      lap_count  <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      timer  <= (state != VIEW || state_n != VIEW || !auto_en || next_req || step) ? '0 : timer + 1'b1;
      rd_iss <= 1'b0;
      rd_val <= rd_iss;
      if (rd_val && state != CLEAR) disp_data <= mem_rddata;
      if (state == CLEAR || clear_req) begin
        mem_we     <= !clr_done;
        mem_wrdata <= '0;
        mem_addr   <= (state == CLEAR && !clr_done) ? mem_addr + 1'b1 : '0;
        rd_pend    <= 1'b0;
        if (clr_done) begin
          lap_count <= '0;
          full      <= 1'b0;
          overflow  <= 1'b0;
          view_addr <= '0;
          disp_data <= '0;
        end
      end else begin
        view_addr <= va_n;
        lap_count <= cnt_eff;
        full      <= cnt_eff == CW'(DEPTH);
        overflow  <= overflow | lap_ovf;
        mem_we    <= lap_ok;
        if (lap_ok) begin
          mem_addr   <= lap_count[AW-1:0];
          mem_wrdata <= time_in;
          rd_pend    <= rd_want && state_n == VIEW;
        end else begin
          rd_pend <= 1'b0;
          if (rd_want && state_n == VIEW) begin
            mem_addr <= va_n;
            rd_iss   <= 1'b1;
          end
        end
      end
    end
  end
endmodule
